// File: rtl/pci_bus_pkg.sv
// pci_bus_pkg: bus commands, target FSM states and address decode helper.
package pci_bus_pkg;
    localparam logic [3:0] CMD_WR = 4'b1000;
    localparam logic [3:0] CMD_RD = 4'b0000;

    typedef enum logic [2:0] {IDLE, WAIT, DATA, TURN, SKIP} state_t;

    function automatic logic addr_hit(input logic [63:0] addr, base, span, align);
        logic [63:0] off;
        off = addr - base;
        return (addr >= base) && (off < span) && ((off & align) == 64'd0);
    endfunction
endpackage

// File: rtl/pci_tgt_ram.sv
// pci_tgt_ram: DEPTH x DW register array, byte-write enables, combinational read, cleared on rst.
module pci_tgt_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [IW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [IW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else begin
            for (int i = 0; i < DW/8; i++)
                if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI-style burst memory target with byte enables and address-range decode.
// Define PCI_TGT_WAIT_EN to insert WAIT_CYC initial wait states after each claim.
module pci_target_mem
    import pci_bus_pkg::*;
#(
    parameter int          DW        = 32,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'd20,
    parameter int          WAIT_CYC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iframe,
    input  logic            iready,
    inout  logic            tready,
    inout  logic            devsel,
    inout  logic [DW-1:0]   AD,
    input  logic [DW/8-1:0] CBE,
    output logic            busy,
    output logic            xfer
);
    localparam int NB = DW / 8;
    localparam int IW = $clog2(DEPTH);
    localparam int SH = $clog2(NB);
`ifdef PCI_TGT_WAIT_EN
    localparam bit WAIT_ON = WAIT_CYC > 0;
    logic [7:0] wcnt;
`else
    localparam bit WAIT_ON = 1'b0 && (WAIT_CYC > 0);
`endif

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] nxt;
    logic          rd;
    logic          done;
    logic          hit;
    logic [3:0]    cmd;
    logic [DW-1:0] rdata;

    assign cmd  = CBE[3:0];
    assign hit  = addr_hit(64'(AD), 64'(BASE_ADDR), 64'(DEPTH * NB), 64'(NB - 1))
                  && (cmd == CMD_WR || cmd == CMD_RD);
    assign done = (state == DATA) && !iready;
    assign nxt  = (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
    assign busy = state inside {WAIT, DATA, TURN};

    // TURN drives both strobes high for one cycle before releasing the bus
    assign devsel = busy ? (state == TURN) : 1'bz;
    assign tready = busy ? (state != DATA) : 1'bz;
    assign AD     = (state == DATA && rd) ? rdata : {DW{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            rd    <= 1'b0;
            xfer  <= 1'b0;
`ifdef PCI_TGT_WAIT_EN
            wcnt  <= '0;
`endif
        end else begin
            xfer <= done;
            case (state)
                IDLE: begin
                    if (!iframe) begin
                        state <= hit ? (WAIT_ON ? WAIT : DATA) : SKIP;
                        idx   <= hit ? IW'((AD - DW'(BASE_ADDR)) >> SH) : idx;
                        rd    <= hit && (cmd == CMD_RD);
`ifdef PCI_TGT_WAIT_EN
                        wcnt  <= '0;
`endif
                    end
                end
`ifdef PCI_TGT_WAIT_EN
                WAIT: begin
                    wcnt  <= wcnt + 1'b1;
                    state <= (wcnt == 8'(WAIT_CYC - 1)) ? DATA : WAIT;
                end
`endif
                DATA: begin
                    if (done) begin
                        idx   <= nxt;
                        state <= iframe ? TURN : DATA;
                    end
                end
                TURN:    state <= IDLE;
                SKIP:    state <= (iframe && iready) ? IDLE : SKIP;
                default: state <= IDLE;
            endcase
        end
    end

    pci_tgt_ram #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (done && !rd),
        .be    (~CBE),
        .waddr (idx),
        .wdata (AD),
        .raddr (idx),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: directed bus transactions with a scoreboard checked on each xfer pulse.
module tb_pci_target_mem;
    import pci_bus_pkg::*;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iframe = 1'b1;
    logic        iready = 1'b1;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_ad = '0;
    logic [3:0]  CBE = '0;
    logic        busy;
    logic        xfer;
    wire         devsel;
    wire         tready;
    wire  [31:0] AD;

    exp_t        sb[$];
    exp_t        e_m;
    logic [31:0] cap = '0;
    int          total = 0;
    int          passed = 0;

    pullup (devsel);
    pullup (tready);
    assign AD = tb_oe ? tb_ad : 'z;

    always #5 clk = ~clk;

    pci_target_mem #(.DW(32), .DEPTH(16), .BASE_ADDR(32'd20), .WAIT_CYC(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .iframe (iframe),
        .iready (iready),
        .tready (tready),
        .devsel (devsel),
        .AD     (AD),
        .CBE    (CBE),
        .busy   (busy),
        .xfer   (xfer)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Each xfer pulse refers to the completion captured one cycle earlier.
    always @(negedge clk) begin
        if (xfer) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL xfer_unexpected: got pulse expected none");
            end else begin
                e_m = sb.pop_front();
                chk(e_m.rd ? "rd_data" : "wr_phase", cap, e_m.data);
            end
        end
        if (!rst && devsel == 1'b0 && tready == 1'b0 && iready == 1'b0) cap = AD;
    end

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        iframe = 1'b0;
        tb_oe  = 1'b1;
        tb_ad  = a;
        CBE    = cmd;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] be, input logic last);
        tb_ad  = d;
        CBE    = be;
        iready = 1'b0;
        iframe = last;
        sb.push_back('{rd: 1'b0, data: d});
        @(posedge clk); #1;
        if (last) begin
            iframe = 1'b1;
            iready = 1'b1;
            tb_oe  = 1'b0;
            CBE    = '0;
        end
    endtask

    task automatic rd(input logic [31:0] exp, input int waits, input logic last);
        tb_oe  = 1'b0;
        iframe = 1'b0;
        iready = 1'b1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("rd_hold", AD, exp);
            @(posedge clk); #1;
        end
        iready = 1'b0;
        iframe = last;
        sb.push_back('{rd: 1'b1, data: exp});
        @(posedge clk); #1;
        iready = 1'b1;
        iframe = last ? 1'b1 : 1'b0;
    endtask

    task automatic turn();
        @(negedge clk);
        chk("turn_busy", 32'(busy), 32'd1);
        chk("turn_devsel", 32'(devsel), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic miss_txn(input logic [31:0] a, input logic [3:0] cmd);
        addr_phase(a, cmd);
        tb_oe = (cmd != CMD_RD);
        for (int i = 0; i < 2; i++) begin
            iready = 1'b0;
            iframe = (i == 1);
            @(negedge clk);
            chk("miss_devsel", 32'(devsel), 32'd1);
            chk("miss_tready", 32'(tready), 32'd1);
            chk("miss_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        iframe = 1'b1;
        iready = 1'b1;
        tb_oe  = 1'b0;
        @(posedge clk); #1;
        addr_phase(32'd32, CMD_RD);
        rd(32'd3, 0, 1'b1);
        turn();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xfer", 32'(xfer), 32'd0);
        chk("rst_devsel", 32'(devsel), 32'd1);
        chk("rst_tready", 32'(tready), 32'd1);
        addr_phase(32'd20, CMD_RD);
        rd(32'd0, 0, 1'b1);
        turn();
        // single write, with claim latency checked right after the address phase
        addr_phase(32'd20, CMD_WR);
        @(negedge clk);
        chk("claim_devsel", 32'(devsel), 32'd0);
        chk("claim_tready", 32'(tready), 32'd0);
        chk("claim_busy", 32'(busy), 32'd1);
        wr(32'd255, 4'h0, 1'b1);
        turn();
        addr_phase(32'd20, CMD_RD);
        rd(32'd255, 0, 1'b1);
        turn();
        addr_phase(32'd24, CMD_WR);
        wr(32'd1, 4'h0, 1'b0);
        wr(32'd2, 4'h0, 1'b0);
        wr(32'd3, 4'h0, 1'b1);
        turn();
        addr_phase(32'd24, CMD_RD);
        rd(32'd1, 0, 1'b0);
        rd(32'd2, 0, 1'b0);
        rd(32'd3, 0, 1'b1);
        turn();
        addr_phase(32'd20, CMD_WR);
        wr(32'hA1B2C3D4, 4'h0, 1'b1);
        turn();
        // wrap from the last word with partial and null byte enables
        addr_phase(32'd80, CMD_WR);
        wr(32'h11111111, 4'h0, 1'b0);
        wr(32'hAABBCCDD, 4'b1100, 1'b0);
        wr(32'hDEADBEEF, 4'hF, 1'b1);
        turn();
        addr_phase(32'd76, CMD_RD);
        rd(32'h00000000, 0, 1'b0);
        rd(32'h11111111, 0, 1'b0);
        rd(32'hA1B2CCDD, 1, 1'b0);
        rd(32'h00000001, 0, 1'b1);
        turn();
        addr_phase(32'd28, CMD_WR);
        wr(32'h1234, 4'h0, 1'b1);
        turn();
        addr_phase(32'd28, CMD_RD);
        rd(32'h1234, 2, 1'b1);
        turn();
        miss_txn(32'd10, CMD_WR);
        miss_txn(32'd22, CMD_WR);
        miss_txn(32'd84, CMD_RD);
        miss_txn(32'd20, 4'b0101);
        // reset after the 2nd of 4 write phases
        addr_phase(32'd20, CMD_WR);
        wr(32'd9, 4'h0, 1'b0);
        wr(32'd8, 4'h0, 1'b0);
        rst    = 1'b1;
        iframe = 1'b1;
        iready = 1'b1;
        tb_oe  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_devsel", 32'(devsel), 32'd1);
        chk("rst_mid_tready", 32'(tready), 32'd1);
        chk("rst_mid_xfer", 32'(xfer), 32'd0);
        addr_phase(32'd20, CMD_RD);
        rd(32'd0, 0, 1'b0);
        rd(32'd0, 0, 1'b0);
        rd(32'd0, 0, 1'b1);
        turn();
        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
